mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 2048x32 data memory (one write port, one sync-read port,
//  1-cycle read latency) between instruction fetch (port A, read-only) and the
//  load/store stage (port B, read/write). Writes pass straight through. Reads are
//  round-robin arbitrated. Same-cycle write/read collisions are forwarded.
//  Sits between the pipeline stages and the memory instance.
// PARAMETERS
//  ADDR_W   11   memory address width (2048 words)
//  DATA_W   32   memory data width
//  CNT_W    16   width of saturating contention counter
// PORTS
//  clk           in   1       rising-edge clock
//  resetn        in   1       asynchronous, active-low reset
//  a_req         in   1       fetch read request; held until a_ready
//  a_addr        in   ADDR_W  fetch read address
//  a_ready       out  1       fetch request granted this cycle (combinational)
//  a_rvalid      out  1       fetch read data valid (1 cycle after grant)
//  a_rdata       out  DATA_W  fetch read data; 0 when a_rvalid=0
//  b_req         in   1       load/store request; held until b_ready
//  b_we          in   1       1 = write, 0 = read (qualified by b_req)
//  b_addr        in   ADDR_W  load/store address
//  b_wdata       in   DATA_W  store data
//  b_ready       out  1       load/store granted this cycle (combinational)
//  b_rvalid      out  1       load data valid (1 cycle after read grant)
//  b_rdata       out  DATA_W  load data; 0 when b_rvalid=0
//  mem_w_adrs    out  ADDR_W  to memory write address (0 when mem_w_en=0)
//  mem_r_adrs    out  ADDR_W  to memory read address (0 when mem_r_en=0)
//  mem_data_in   out  DATA_W  to memory write data (0 when mem_w_en=0)
//  mem_w_en      out  1       to memory write enable
//  mem_r_en      out  1       to memory read enable
//  mem_data_out  in   DATA_W  from memory registered read data
//  conflict_cnt  out  CNT_W   cycles with both read requests pending, saturating
// BEHAVIOUR
//  - Reset (async, resetn=0): prio<=A, owner<=NONE, fwd_hit<=0, fwd_data<=0,
//    conflict_cnt<=0; a/b_rvalid=0, a/b_rdata=0. While resetn=0: a_ready,
//    b_ready, mem_w_en and mem_r_en are forced to 0.
//  - Write: b_req&b_we -> b_ready=1, mem_w_en=1 in the same cycle. Never stalls.
//  - Reads: ra=a_req; rb=b_req&~b_we. Exactly one asserted -> grant it.
//    Both asserted -> grant prio side, prio<=other side at the clock edge.
//    Uncontested grants do not change prio.
//  - Grant: mem_r_en=1, mem_r_adrs=granted addr, granted *_ready=1.
//    owner<=A/B at the edge; NONE when no read is granted.
//  - Response: the cycle after the grant, owner's rvalid=1.
//    rdata = fwd_hit ? fwd_data : mem_data_out. Non-owner rvalid=0, rdata=0.
//    Responses cannot be back-pressured.
//    Sustained rate: one read plus one write per cycle.
//  - Forward: fwd_hit<=mem_w_en&mem_r_en&(mem_w_adrs==mem_r_adrs);
//    fwd_data<=mem_data_in. This covers a B write colliding with an A read.
//  - conflict_cnt increments when ra&rb. Holds at 2^CNT_W-1; never wraps.
//  - Reset mid-operation: an in-flight read is dropped (no rvalid). The
//    requester reissues after reset.
// STRUCTURE
//  - Package mem_arb_pkg: ADDR_W/DATA_W defaults; owner enum
//    {OWN_NONE, OWN_A, OWN_B}; port id constants.
//  - Sub-module rr_arb2: 2-way round-robin arbiter with registered priority
//    bit (async reset to A).
//  - Forwarding, owner tracking and the counter live in mem_arbiter.
//  - The memory instance is external.
// TESTING
//  1 resetn=0 for 3 cycles with a_req=1, b_req=1 -> a/b_ready=0,
//    mem_r_en=mem_w_en=0, rvalid=0, conflict_cnt=0.
//  2 B writes 0xDEADBEEF to 0x010, then A reads 0x010 -> a_ready same cycle;
//    next cycle a_rvalid=1, a_rdata=0xDEADBEEF, b_rvalid=0.
//  3 A and B both read continuously for 4 cycles -> grants A,B,A,B;
//    conflict_cnt=4; each rvalid lands 1 cycle after its grant.
//  4 B writes 0x12345678 to 0x7FF in the same cycle A reads 0x7FF ->
//    next cycle a_rdata=0x12345678 (forwarded, not stale).
//  5 A read granted, then resetn=0 before the next edge -> a_rvalid stays 0;
//    after release, a contested read is granted to A first.
//  6 Hold both read requests for 65540 cycles -> conflict_cnt=0xFFFF, no wrap.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  // Which requester owns the read response arriving next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority flips only when both sides request.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_a  = req_a & (~req_b | (prio_q == PORT_A));
    gnt_b  = req_b & (~req_a | (prio_q == PORT_B));
    prio_d = prio_q;
    if (req_a & req_b) begin
      prio_d = gnt_a ? PORT_B : PORT_A;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio_q <= PORT_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one sync-read/one-write data memory between fetch (A) and load/store (B),
// with round-robin reads and same-cycle write-to-read forwarding.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_w_adrs,
  output logic [ADDR_W-1:0] mem_r_adrs,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_w_en,
  output logic              mem_r_en,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic ra, rb, wr;
  logic gnt_a, gnt_b;

  owner_e            owner_q, owner_d;
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] resp_data;

  // Requests are masked by resetn so nothing is granted while reset is held.
  assign ra = a_req & resetn;
  assign rb = b_req & ~b_we & resetn;
  assign wr = b_req & b_we & resetn;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .resetn (resetn),
    .req_a  (ra),
    .req_b  (rb),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  always_comb begin
    a_ready     = gnt_a;
    b_ready     = gnt_b | wr;
    mem_r_en    = gnt_a | gnt_b;
    mem_r_adrs  = '0;
    if (gnt_a) begin
      mem_r_adrs = a_addr;
    end else if (gnt_b) begin
      mem_r_adrs = b_addr;
    end
    mem_w_en    = wr;
    mem_w_adrs  = wr ? b_addr : '0;
    mem_data_in = wr ? b_wdata : '0;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_a) begin
      owner_d = OWN_A;
    end else if (gnt_b) begin
      owner_d = OWN_B;
    end
    // Memory returns pre-write data on a same-address collision; capture the new value.
    fwd_hit_d  = mem_w_en & mem_r_en & (mem_w_adrs == mem_r_adrs);
    fwd_data_d = mem_data_in;
    cnt_d      = cnt_q;
    if (ra & rb && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q    <= OWN_NONE;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      owner_q    <= owner_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    resp_data = fwd_hit_q ? fwd_data_q : mem_data_out;
    a_rvalid  = (owner_q == OWN_A);
    b_rvalid  = (owner_q == OWN_B);
    a_rdata   = a_rvalid ? resp_data : '0;
    b_rdata   = b_rvalid ? resp_data : '0;
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural read-before-write memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        a_req;
  logic [10:0] a_addr;
  logic        a_ready, a_rvalid;
  logic [31:0] a_rdata;
  logic        b_req, b_we;
  logic [10:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ready, b_rvalid;
  logic [31:0] b_rdata;
  logic [10:0] mem_w_adrs, mem_r_adrs;
  logic [31:0] mem_data_in;
  logic        mem_w_en, mem_r_en;
  logic [31:0] mem_data_out;
  logic [15:0] conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [2048];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .a_req        (a_req),
    .a_addr       (a_addr),
    .a_ready      (a_ready),
    .a_rvalid     (a_rvalid),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_ready      (b_ready),
    .b_rvalid     (b_rvalid),
    .b_rdata      (b_rdata),
    .mem_w_adrs   (mem_w_adrs),
    .mem_r_adrs   (mem_r_adrs),
    .mem_data_in  (mem_data_in),
    .mem_w_en     (mem_w_en),
    .mem_r_en     (mem_r_en),
    .mem_data_out (mem_data_out),
    .conflict_cnt (conflict_cnt)
  );

  // Read returns the old contents on a same-cycle write, so forwarding is exercised.
  always @(posedge clk) begin
    if (mem_r_en) mem_data_out <= mem[mem_r_adrs];
    if (mem_w_en) mem[mem_w_adrs] <= mem_data_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_addr = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 | i;
    mem_data_out = '0;

    // 1: reset held with both requests pending
    idle_inputs();
    resetn = 1'b0;
    a_req  = 1'b1; b_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ready",  32'(a_ready),  0);
    check("rst_b_ready",  32'(b_ready),  0);
    check("rst_mem_r_en", 32'(mem_r_en), 0);
    check("rst_mem_w_en", 32'(mem_w_en), 0);
    check("rst_a_rvalid", 32'(a_rvalid), 0);
    check("rst_b_rvalid", 32'(b_rvalid), 0);
    check("rst_cnt",      32'(conflict_cnt), 0);
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;

    // 2: B writes, then A reads it back
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 11'h010; b_wdata = 32'hDEAD_BEEF;
    #1;
    check("wr_b_ready",  32'(b_ready),    1);
    check("wr_w_en",     32'(mem_w_en),   1);
    check("wr_w_adrs",   32'(mem_w_adrs), 32'h010);
    check("wr_w_data",   mem_data_in,     32'hDEAD_BEEF);
    @(negedge clk);
    idle_inputs();
    a_req = 1'b1; a_addr = 11'h010;
    #1;
    check("rd_a_ready",  32'(a_ready),    1);
    check("rd_r_adrs",   32'(mem_r_adrs), 32'h010);
    @(posedge clk); #1;
    check("rd_a_rvalid", 32'(a_rvalid), 1);
    check("rd_a_rdata",  a_rdata,       32'hDEAD_BEEF);
    check("rd_b_rvalid", 32'(b_rvalid), 0);
    check("rd_b_rdata",  b_rdata,       0);

    // 3: contested reads alternate A,B,A,B
    @(negedge clk);
    idle_inputs();
    a_req = 1'b1; a_addr = 11'h030;
    b_req = 1'b1; b_addr = 11'h020;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_a_ready", 32'(a_ready), 32'((k % 2) == 0));
      check("rr_b_ready", 32'(b_ready), 32'((k % 2) == 1));
      @(posedge clk); #1;
      check("rr_a_rvalid", 32'(a_rvalid), 32'((k % 2) == 0));
      check("rr_b_rvalid", 32'(b_rvalid), 32'((k % 2) == 1));
      check("rr_rdata", (k % 2 == 0) ? a_rdata : b_rdata,
            (k % 2 == 0) ? 32'hA000_0030 : 32'hA000_0020);
      @(negedge clk);
    end
    check("rr_cnt", 32'(conflict_cnt), 4);

    // 4: write and read to the same address in one cycle
    idle_inputs();
    a_req = 1'b1; a_addr = 11'h7FF;
    b_req = 1'b1; b_we = 1'b1; b_addr = 11'h7FF; b_wdata = 32'h1234_5678;
    #1;
    check("fw_a_ready", 32'(a_ready), 1);
    check("fw_b_ready", 32'(b_ready), 1);
    @(posedge clk); #1;
    check("fw_a_rvalid", 32'(a_rvalid), 1);
    check("fw_a_rdata",  a_rdata,       32'h1234_5678);
    check("fw_b_rvalid", 32'(b_rvalid), 0);

    // 5: move priority to B, then reset with an A read in flight
    @(negedge clk);
    idle_inputs();
    a_req = 1'b1; a_addr = 11'h030;
    b_req = 1'b1; b_addr = 11'h020;
    #1;
    check("pre_a_ready", 32'(a_ready), 1);
    @(negedge clk);
    b_req = 1'b0;
    #1;
    check("pre_a_rvalid", 32'(a_rvalid), 1);
    check("inflt_a_ready", 32'(a_ready), 1);
    #1;
    resetn = 1'b0;
    #1;
    check("rstmid_a_ready", 32'(a_ready),  0);
    check("rstmid_r_en",    32'(mem_r_en), 0);
    @(posedge clk); #1;
    check("rstmid_a_rvalid", 32'(a_rvalid), 0);
    check("rstmid_cnt",      32'(conflict_cnt), 0);
    @(negedge clk);
    resetn = 1'b1;
    b_req  = 1'b1;
    #1;
    check("post_a_ready", 32'(a_ready), 1);
    check("post_b_ready", 32'(b_ready), 0);
    @(posedge clk); #1;
    check("post_a_rvalid", 32'(a_rvalid), 1);
    check("post_a_rdata",  a_rdata,       32'hA000_0030);
    check("post_cnt",      32'(conflict_cnt), 1);

    // 6: counter saturates and stays there
    repeat (65540) @(posedge clk);
    #1;
    check("sat_cnt", 32'(conflict_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold", 32'(conflict_cnt), 32'hFFFF);

    @(negedge clk);
    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
